sysbus_copy_master: RTL

SYSBUS_COPY_MASTER -- requirements
Module: sysbus_copy_master

---
 rtl/sysbus_copy_master.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sysbus_copy_master.sv
// rtl/sysbus_copy_master.sv - word-by-word memory copy engine on a granted system bus
// Each word is one read, one capture cycle and one write; every bus output is a flop.
module sysbus_copy_master #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             bus_gnt,
  output logic             system_bus_en,
  output logic             system_bus_rdwr,
  output logic [31:0]      system_bus_addr,
  output logic [31:0]      system_bus_wr_data,
  output logic [3:0]       system_bus_mask,
  input  logic [31:0]      system_bus_rd_data,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_RWAIT = 3'd2,
    S_WR    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [CNT_W-1:0] cnt_q;

  logic [31:0]      src_d;
  logic [31:0]      dst_d;
  logic [CNT_W-1:0] cnt_d;
  logic             misaligned;

  always_comb begin
    src_d      = src_q + 32'd4;
    dst_d      = dst_q + 32'd4;
    cnt_d      = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);
  end

  // Outputs are loaded on the transition into the state that presents them,
  // so the bus sees nothing combinational from bus_gnt or rd_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= S_IDLE;
      src_q              <= 32'd0;
      dst_q              <= 32'd0;
      cnt_q              <= '0;
      system_bus_en      <= 1'b0;
      system_bus_rdwr    <= 1'b0;
      system_bus_addr    <= 32'd0;
      system_bus_wr_data <= 32'd0;
      system_bus_mask    <= 4'h0;
      busy               <= 1'b0;
      done               <= 1'b0;
      err                <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (misaligned) begin
              state_q <= S_DONE;
              done    <= 1'b1;
              err     <= 1'b1;
            end else if (word_count == '0) begin
              state_q <= S_DONE;
              done    <= 1'b1;
            end else begin
              src_q           <= src_addr;
              dst_q           <= dst_addr;
              cnt_q           <= word_count;
              state_q         <= S_RD;
              system_bus_en   <= 1'b1;
              system_bus_rdwr <= 1'b0;
              system_bus_addr <= src_addr;
            end
          end
        end
        S_RD: begin
          if (bus_gnt) begin
            state_q       <= S_RWAIT;
            system_bus_en <= 1'b0;
          end
        end
        S_RWAIT: begin
          state_q            <= S_WR;
          system_bus_en      <= 1'b1;
          system_bus_rdwr    <= 1'b1;
          system_bus_addr    <= dst_q;
          system_bus_wr_data <= system_bus_rd_data;
          system_bus_mask    <= 4'hF;
        end
        S_WR: begin
          if (bus_gnt) begin
            src_q           <= src_d;
            dst_q           <= dst_d;
            cnt_q           <= cnt_d;
            system_bus_rdwr <= 1'b0;
            system_bus_mask <= 4'h0;
            if (cnt_d == '0) begin
              state_q       <= S_DONE;
              system_bus_en <= 1'b0;
              done          <= 1'b1;
            end else begin
              state_q         <= S_RD;
              system_bus_en   <= 1'b1;
              system_bus_addr <= src_d;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_q       <= S_IDLE;
          system_bus_en <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule
